// File: rtl/muldiv_unit_pkg.sv
// Shared types for the EX-stage multiply/divide unit.
// Operation codes and FSM state encodings.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        EXE_MD_MUL  = 2'd0,
        EXE_MD_DIV  = 2'd1,
        EXE_MD_MTHI = 2'd2,
        EXE_MD_MTLO = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_MUL  = 3'd1,
        MD_DIV  = 3'd2,
        MD_FIX  = 3'd3,
        MD_DZ   = 3'd4
    } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the mul/div unit.
// master = EX issue side, slave = muldiv_unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    import muldiv_unit_pkg::*;

    logic             start;
    md_op_e           oper;
    logic             sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, oper, sign, a, b, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, oper, sign, a, b, cancel,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_unit_md_div_step.sv
// One restoring-division step: shift in a dividend bit, try subtract.
// Requires rem < divisor on entry, so the result always fits WIDTH bits.
module md_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nx,
    output logic             qbit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        trial  = {rem, din};
        diff   = trial - {1'b0, divisor};
        qbit   = ~diff[WIDTH];
        rem_nx = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit running beside the EX ALU.
// Works on magnitudes; sign is restored in the FIX cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic         clk,
    input logic         rst,
    muldiv_unit_if.slave md
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [W2-1:0]    acc;
    logic [WIDTH-1:0] opb;
    logic             neg_q;
    logic             neg_r;
    logic             div_r;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] rem_nx;
    logic             qbit;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign md.busy = busy_q;
    assign md.done = done_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

    always_comb begin
        sa    = md.sign & md.a[WIDTH-1];
        sb    = md.sign & md.b[WIDTH-1];
        a_mag = sa ? -md.a : md.a;
        b_mag = sb ? -md.b : md.b;
    end

    // Multiplier sits in acc low half and drains out as the sum shifts in.
    always_comb begin
        mul_sum = {1'b0, acc[W2-1:WIDTH]};
        if (acc[0])
            mul_sum = mul_sum + {1'b0, opb};
    end

    // Divide: acc = {partial remainder, dividend shifting into quotient}.
    md_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem    (acc[W2-1:WIDTH]),
        .din    (acc[WIDTH-1]),
        .divisor(opb),
        .rem_nx (rem_nx),
        .qbit   (qbit)
    );

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div_r  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (md.cancel) begin
                state  <= MD_IDLE;
                busy_q <= 1'b0;
            end else begin
                unique case (state)
                    MD_IDLE: begin
                        if (md.start) begin
                            unique case (md.oper)
                                EXE_MD_MUL: begin
                                    state  <= MD_MUL;
                                    busy_q <= 1'b1;
                                    cnt    <= '0;
                                    acc    <= {{WIDTH{1'b0}}, b_mag};
                                    opb    <= a_mag;
                                    neg_q  <= sa ^ sb;
                                    neg_r  <= sa;
                                    div_r  <= 1'b0;
                                end
                                EXE_MD_DIV: begin
                                    busy_q <= 1'b1;
                                    cnt    <= '0;
                                    div_r  <= 1'b1;
                                    neg_q  <= sa ^ sb;
                                    neg_r  <= sa;
                                    opb    <= b_mag;
                                    if (md.b == '0) begin
                                        state <= MD_DZ;
                                        acc   <= {{WIDTH{1'b0}}, md.a};
                                    end else begin
                                        state <= MD_DIV;
                                        acc   <= {{WIDTH{1'b0}}, a_mag};
                                    end
                                end
                                EXE_MD_MTHI: hi_q <= md.a;
                                EXE_MD_MTLO: lo_q <= md.a;
                            endcase
                        end
                    end
                    MD_MUL: begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST)
                            state <= MD_FIX;
                    end
                    MD_DIV: begin
                        acc <= {rem_nx, acc[WIDTH-2:0], qbit};
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST)
                            state <= MD_FIX;
                    end
                    MD_FIX: begin
                        if (div_r) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= MD_IDLE;
                    end
                    MD_DZ: begin
                        hi_q   <= acc[WIDTH-1:0];
                        lo_q   <= '1;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= MD_IDLE;
                    end
                    default: begin
                        state  <= MD_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: mul/div results, latency, MT writes,
// start-while-busy, cancel and asynchronous reset.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .md (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input md_op_e op,
                          input logic sg, input logic [31:0] av,
                          input logic [31:0] bv, input int exp_busy,
                          input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit inject);
        int nb;
        int nd;
        int nbd;
        logic [31:0] hd;
        logic [31:0] ld;
        nb  = 0;
        nd  = 0;
        nbd = 0;
        hd  = 'x;
        ld  = 'x;
        @(negedge clk);
        bus.start = 1'b1;
        bus.oper  = op;
        bus.sign  = sg;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        bus.sign  = ~sg;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (bus.busy) nb++;
            if (bus.done) begin
                nd++;
                hd = bus.hi;
                ld = bus.lo;
                if (bus.busy) nbd++;
            end
            if (inject && i == 5) begin
                bus.start = 1'b1;
                bus.oper  = EXE_MD_DIV;
                bus.a     = 32'd100;
                bus.b     = 32'd7;
            end
            if (inject && i == 7) bus.start = 1'b0;
        end
        chk({tag, ".busy"}, 64'(nb), 64'(exp_busy));
        chk({tag, ".done"}, 64'(nd), 64'd1);
        chk({tag, ".hi"}, {32'h0, hd}, {32'h0, exp_hi});
        chk({tag, ".lo"}, {32'h0, ld}, {32'h0, exp_lo});
        chk({tag, ".donebusy"}, 64'(nbd), 64'd0);
    endtask

    initial begin
        int nd;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.oper   = EXE_MD_MUL;
        bus.sign   = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.cancel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.busy", {63'h0, bus.busy}, 64'd0);
        chk("rst.done", {63'h0, bus.done}, 64'd0);
        chk("rst.hi", {32'h0, bus.hi}, 64'd0);
        chk("rst.lo", {32'h0, bus.lo}, 64'd0);
        rst = 1'b0;

        run_op("mulu", EXE_MD_MUL, 1'b0, 32'hFFFF_FFFF, 32'd2, 33,
               32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run_op("muls", EXE_MD_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, 33,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("mulu2", EXE_MD_MUL, 1'b0, 32'hFFFF_FFFD, 32'd5, 33,
               32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
        run_op("divs", EXE_MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 33,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divovf", EXE_MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
               33, 32'h0, 32'h8000_0000, 1'b0);
        run_op("divu", EXE_MD_DIV, 1'b0, 32'd100, 32'd7, 33,
               32'd2, 32'd14, 1'b0);
        run_op("divz", EXE_MD_DIV, 1'b0, 32'h0000_1234, 32'h0, 1,
               32'h0000_1234, 32'hFFFF_FFFF, 1'b0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.oper  = EXE_MD_MTHI;
        bus.a     = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        chk("mthi.hi", {32'h0, bus.hi}, 64'hA5A5_A5A5);
        chk("mthi.busy", {63'h0, bus.busy}, 64'd0);
        bus.oper = EXE_MD_MTLO;
        bus.a    = 32'h5A5A_5A5A;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("mtlo.lo", {32'h0, bus.lo}, 64'h5A5A_5A5A);
        chk("mtlo.hi", {32'h0, bus.hi}, 64'hA5A5_A5A5);
        chk("mtlo.busy", {63'h0, bus.busy}, 64'd0);

        run_op("ignore", EXE_MD_MUL, 1'b0, 32'd3, 32'd4, 33,
               32'd0, 32'd12, 1'b1);

        @(negedge clk);
        bus.start = 1'b1;
        bus.oper  = EXE_MD_DIV;
        bus.sign  = 1'b0;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("cancel.pre", {63'h0, bus.busy}, 64'd1);
        bus.cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        chk("cancel.busy", {63'h0, bus.busy}, 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("cancel.done", 64'(nd), 64'd0);
        chk("cancel.hi", {32'h0, bus.hi}, 64'd0);
        chk("cancel.lo", {32'h0, bus.lo}, 64'd12);

        @(negedge clk);
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.oper   = EXE_MD_MTHI;
        bus.a      = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        chk("idlecan.hi", {32'h0, bus.hi}, 64'd0);
        chk("idlecan.busy", {63'h0, bus.busy}, 64'd0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.oper  = EXE_MD_MUL;
        bus.a     = 32'd7;
        bus.b     = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("arst.pre", {63'h0, bus.busy}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.busy", {63'h0, bus.busy}, 64'd0);
        chk("arst.done", {63'h0, bus.done}, 64'd0);
        chk("arst.hi", {32'h0, bus.hi}, 64'd0);
        chk("arst.lo", {32'h0, bus.lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage. It runs in parallel with the single-cycle ALU and consumes the same forwarded operands a/b.
- Owns the architectural HI/LO registers: MULT(U) and DIV(U) compute into them; MTHI and MTLO write them directly.
- Asserts busy so the hazard unit stalls any MFHI/MFLO or new mul/div until the result is committed.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  request; sampled only when busy=0
- oper  in  2  EXE_MD_MUL=0, EXE_MD_DIV=1, EXE_MD_MTHI=2, EXE_MD_MTLO=3
- sign  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU); ignored for MTHI/MTLO
- a  in  WIDTH  rs operand (multiplicand/dividend/MT source)
- b  in  WIDTH  rt operand (multiplier/divisor)
- cancel  in  1  abort in-flight operation (exception flush)
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse in the cycle HI/LO show a new mul/div result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal datapath regs=0.
- FSM states:
  - IDLE: start with MUL -> MUL state; start with DIV and b!=0 -> DIV state; start with DIV and b==0 -> DZ. MTHI/MTLO write their register at that edge and stay in IDLE; busy stays 0.
  - MUL and DIV: 32 iterations, counter 0..31, then FIX.
  - FIX: one cycle; apply sign correction, write hi/lo, pulse done, return to IDLE.
  - DZ: one cycle; hi=a, lo={WIDTH{1}}, pulse done, return to IDLE.
- At accept, a, b and sign are captured into internal regs. Operands may change afterwards without effect.
- Signed operation: the core works on magnitudes |a|, |b|. Sign flags are latched at accept.
- Multiply:
  - Shift-add on a 64-bit accumulator.
  - FIX negates the 64-bit product if sign && (a[31]^b[31]).
  - Then {hi,lo} = product.
- Divide:
  - Restoring, one quotient bit per cycle.
  - FIX negates the quotient if sign && (a[31]^b[31]); negates the remainder if sign && a[31].
  - Then hi = remainder, lo = quotient.
  - 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0. No trap.
- Latency:
  - Start accepted at edge N: busy=1 from N+1. The final iteration is on edge N+32, so busy is high during cycles N+1..N+33.
  - hi/lo are updated and done=1 after edge N+33; busy=0 in that same cycle.
  - Divide-by-zero: busy for 1 cycle, done after edge N+1.
- start while busy=1 is ignored (no queueing). The hazard unit must hold the instruction.
- cancel:
  - In MUL, DIV, FIX or DZ: return to IDLE at the next edge. hi/lo unchanged, no done pulse.
  - In IDLE: cancel has priority over start, so nothing is accepted or written that edge.
- hi/lo change only on MTHI/MTLO accept, in FIX, in DZ, or on reset.

Decomposition:
- mips_define.vh gains:
  - EXE_MD_MUL, EXE_MD_DIV, EXE_MD_MTHI, EXE_MD_MTLO
  - state encodings MD_IDLE, MD_MUL, MD_DIV, MD_FIX, MD_DZ
- One sub-module, md_div_step: combinational single restoring step with inputs partial remainder, dividend bit and divisor; outputs next remainder and quotient bit. It is reusable by a future radix-4 version.
- Magnitude, negate and multiply logic stay in muldiv_unit.

Test Plan:
- Unsigned MUL a=0xFFFFFFFF, b=2, sign=0 -> busy high 33 cycles; then hi=0x00000001, lo=0xFFFFFFFE, done pulses once.
- Signed MUL a=-3 (0xFFFFFFFD), b=5, sign=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Repeat with sign=0 -> hi=0x00000004, lo=0xFFFFFFF1.
- Signed DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then 0x80000000/0xFFFFFFFF signed -> lo=0x80000000, hi=0.
- DIV by zero a=0x1234, b=0 -> busy exactly 1 cycle; hi=0x00001234, lo=0xFFFFFFFF.
- MTHI a=0xA5A5A5A5 then MTLO a=0x5A5A5A5A in consecutive cycles -> busy stays 0; hi and lo hold the values after each edge. Second start issued mid-MUL -> ignored; first result unaffected.
- Cancel and reset:
  - Start DIV, assert cancel at iteration 10 -> busy=0 next cycle, hi/lo keep old values, no done.
  - Assert rst asynchronously mid-MUL -> busy, done, hi, lo all 0 immediately, without waiting for a clock edge.
